// File: rtl/edge_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : edge_arb_pkg
//  Description : Shared types and the round-robin pick function for the
//                edge event arbiter.
//  Contents    : edge_mode_e  - per-line edge select encoding
//                arb_state_e  - output FSM states
//                rr_pick()    - round-robin winner search
//  Revision    : 1.0 - initial release
// ============================================================================
package edge_arb_pkg;

  // Widest line count rr_pick can search.
  localparam int MAX_N = 32;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

  // Returns the first set bit of pend, searching upward from last+1 and
  // wrapping modulo n. The loop bound is fixed so it unrolls statically;
  // offsets beyond n are masked out.
  function automatic int rr_pick(input logic [MAX_N-1:0] pend,
                                 input int last,
                                 input int n);
    int   pick;
    int   idx;
    logic found;
    pick  = 0;
    found = 1'b0;
    for (int off = 1; off <= MAX_N; off++) begin
      idx = (last + off) % n;
      if (!found && (off <= n) && pend[idx[4:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_event_arbiter_cell.sv
`default_nettype none
// ============================================================================
//  Module      : edge_detect_cell
//  Description : One input line: history bit, mode-gated edge detection and
//                a single-entry pending slot.
//  Ports       : clk, rst   - clock, synchronous active-high reset
//                din        - line input (already synchronous)
//                mode       - edge select for this line (edge_mode_e)
//                grant      - slot is being taken by the arbiter this cycle
//                pend/pkind - slot occupied / kind of held event (1 = rise)
//                drop       - an event was lost this cycle (slot busy)
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_detect_cell
  import edge_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic [1:0] mode,
  input  logic       grant,
  output logic       pend,
  output logic       pkind,
  output logic       drop
);

  logic       din_q;
  edge_mode_e w_mode;
  logic       w_rise;
  logic       w_fall;
  logic       w_det;

  assign w_mode = edge_mode_e'(mode);
  assign w_rise = din & ~din_q & ((w_mode == EDGE_RISE) || (w_mode == EDGE_BOTH));
  assign w_fall = ~din & din_q & ((w_mode == EDGE_FALL) || (w_mode == EDGE_BOTH));
  assign w_det  = w_rise | w_fall;

  // A slot being granted this cycle is free to take the new event.
  assign drop = w_det & pend & ~grant;

  always_ff @(posedge clk) begin
    // History tracks din even in reset so a line held high across reset
    // release does not look like a rising edge.
    din_q <= din;
    if (rst) begin
      pend  <= 1'b0;
      pkind <= 1'b0;
    end else if (w_det && (!pend || grant)) begin
      pend  <= 1'b1;
      pkind <= w_rise;
    end else if (grant) begin
      pend  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/edge_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : edge_event_arbiter
//  Description : Captures per-line rising/falling edges, holds one pending
//                event per line and serialises them round-robin to a single
//                valid/ready consumer. Lost events set a sticky flag.
//  Ports       : clk, rst         - clock, synchronous active-high reset
//                din[N]           - input lines
//                mode[2N]         - per-line edge select, [2i+1:2i] = line i
//                ev_valid/ev_ready- consumer handshake
//                ev_id, ev_kind   - offered line index, 1 = rise / 0 = fall
//                ovf[N], ovf_clr  - sticky overflow flags and their clear
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N   = 2,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   din,
  input  logic [2*N-1:0] mode,
  output logic           ev_valid,
  output logic [IDW-1:0] ev_id,
  output logic           ev_kind,
  input  logic           ev_ready,
  output logic [N-1:0]   ovf,
  input  logic           ovf_clr
);

  logic [N-1:0]   w_pend;
  logic [N-1:0]   w_pkind;
  logic [N-1:0]   w_drop;
  logic [N-1:0]   w_grant;
  logic [IDW-1:0] w_pick;
  logic           w_any;
  logic           w_load;

  arb_state_e     r_state;
  logic [IDW-1:0] r_last;

  assign w_any  = |w_pend;
  assign w_pick = IDW'(rr_pick(MAX_N'(w_pend), int'(r_last), N));

  // A new winner is taken from IDLE, or from OFFER on a transfer
  // (back-to-back). Only slots registered before this edge compete.
  assign w_load  = w_any && ((r_state == IDLE) || ev_ready);
  assign w_grant = w_load ? (N'(1) << w_pick) : '0;

  for (genvar i = 0; i < N; i++) begin : g_line
    edge_detect_cell u_cell (
      .clk   (clk),
      .rst   (rst),
      .din   (din[i]),
      .mode  (mode[2*i+1:2*i]),
      .grant (w_grant[i]),
      .pend  (w_pend[i]),
      .pkind (w_pkind[i]),
      .drop  (w_drop[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_last   <= IDW'(N - 1);
      ev_valid <= 1'b0;
      ev_id    <= '0;
      ev_kind  <= 1'b0;
      ovf      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_state  <= OFFER;
            ev_valid <= 1'b1;
            ev_id    <= w_pick;
            ev_kind  <= w_pkind[w_pick];
            r_last   <= w_pick;
          end
        end
        OFFER: begin
          if (w_load) begin
            ev_id    <= w_pick;
            ev_kind  <= w_pkind[w_pick];
            r_last   <= w_pick;
          end else if (ev_ready) begin
            r_state  <= IDLE;
            ev_valid <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          ev_valid <= 1'b0;
        end
      endcase
      // Set has priority over clear.
      ovf <= (ovf & ~{N{ovf_clr}}) | w_drop;
    end
  end

endmodule
`default_nettype wire
